// File: rtl/line_burst_adapter.sv
// Cache-line to beat-burst adapter: one outstanding 256-bit line moved as ascending 64-bit beats.
// Optional ADAPTER_FAST_RESP_EN: completion is signalled combinationally on the last beat (no DONE cycle).
`timescale 1ns/1ps
module line_burst_adapter #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] line_address,
    input  logic                  line_read,
    input  logic                  line_write,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic                  line_resp,
    output logic [ADDR_WIDTH-1:0] burst_address,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp,
    output logic                  busy,
    output logic                  err
);

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int OFFS  = $clog2(LINE_WIDTH / 8);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {{(ADDR_WIDTH-OFFS){1'b1}}, {OFFS{1'b0}}};

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

`ifdef ADAPTER_FAST_RESP_EN
    localparam state_t AFTER_LAST = IDLE;
`else
    localparam state_t AFTER_LAST = DONE;
`endif

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LINE_WIDTH-1:0]  buf_q, buf_d;
    logic [LINE_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   last_beat;

    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (line_read || line_write) begin
                    addr_d = line_address;
                    cnt_d  = '0;
                end
                // A simultaneous read+write is served as a read and flagged.
                if (line_read) begin
                    state_d = RD;
                    if (line_write) err_d = 1'b1;
                end else if (line_write) begin
                    state_d = WR;
                    buf_d   = line_wdata;
                end
                if (burst_resp) err_d = 1'b1;
            end
            RD: begin
                if (burst_resp) begin
                    buf_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = burst_rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        rdata_d = {burst_rdata, buf_q[LINE_WIDTH-BEAT_WIDTH-1:0]};
                        state_d = AFTER_LAST;
                    end
                end
            end
            WR: begin
                if (burst_resp) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) state_d = AFTER_LAST;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (burst_resp) err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Line buffer is pure data; its contents are meaningless outside a transaction.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign busy          = (state_q != IDLE);
    assign burst_read    = (state_q == RD);
    assign burst_write   = (state_q == WR);
    assign burst_address = addr_q & ADDR_MASK;
    assign burst_wdata   = (state_q == WR) ? buf_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] : '0;
    assign err           = err_q;

`ifdef ADAPTER_FAST_RESP_EN
    assign line_resp  = (state_q == RD || state_q == WR) && burst_resp && last_beat;
    assign line_rdata = (state_q == RD && burst_resp && last_beat) ? rdata_d : rdata_q;
`else
    assign line_resp  = (state_q == DONE);
    assign line_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter: bench-side memory model plus a per-cycle line/err/address checker.
`timescale 1ns/1ps
module tb_line_burst_adapter;

`ifdef ADAPTER_FAST_RESP_EN
    localparam int FAST = 1;
`else
    localparam int FAST = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  line_address;
    logic         line_read, line_write;
    logic [255:0] line_wdata, line_rdata;
    logic         line_resp;
    logic [31:0]  burst_address;
    logic         burst_read, burst_write;
    logic [63:0]  burst_wdata, burst_rdata;
    logic         burst_resp;
    logic         busy, err;

    line_burst_adapter dut (
        .clk(clk), .reset(reset),
        .line_address(line_address), .line_read(line_read), .line_write(line_write),
        .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
        .burst_address(burst_address), .burst_read(burst_read), .burst_write(burst_write),
        .burst_wdata(burst_wdata), .burst_rdata(burst_rdata), .burst_resp(burst_resp),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model state: what the line port must show, and the transaction in flight.
    logic [255:0] exp_rdata = '0;
    bit           exp_err = 0;
    bit           err_next = 0;
    bit           outstanding = 0;
    bit           cur_is_read = 0;
    logic [31:0]  cur_addr = '0;
    logic [255:0] cur_line = '0;
    logic [255:0] cur_wline = '0;
    logic [255:0] mem_line = '0;
    int           stall_n = 0;
    bit           force_resp = 0;
    bit           mon_en = 0;
    int           beats_done = 0;
    int           beat_idx = 0;
    int           stall_cnt = 0;

    localparam logic [255:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] W2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                   64'h0F1E_2D3C_4B5A_6978, 64'h8796_A5B4_C3D2_E1F0};

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory model and per-cycle checker share one process so ordering is fixed.
    always @(negedge clk) begin
        burst_resp  = 1'b0;
        burst_rdata = '0;
        if (force_resp) begin
            burst_resp = 1'b1;
        end else if (reset || !(burst_read || burst_write)) begin
            beat_idx  = 0;
            stall_cnt = 0;
        end else if (beat_idx < 4) begin
            if (stall_cnt < stall_n) begin
                stall_cnt++;
            end else begin
                burst_resp  = 1'b1;
                burst_rdata = mem_line[64*beat_idx +: 64];
                if (burst_write) chk("write_beat", burst_wdata, cur_wline[64*beat_idx +: 64]);
                beat_idx++;
                stall_cnt = 0;
                beats_done++;
            end
        end
        #1;
        if (mon_en) begin
            if (!outstanding) chk("resp_without_request", line_resp, 0);
            if (line_resp && outstanding) begin
                if (cur_is_read) exp_rdata = cur_line;
                outstanding = 0;
            end
            chk("line_rdata", line_rdata, exp_rdata);
            chk("err", err, exp_err);
            chk("read_write_exclusive", burst_read && burst_write, 0);
            if (burst_read || burst_write) begin
                chk("burst_address", burst_address, cur_addr & 32'hFFFF_FFE0);
                chk("burst_direction", burst_read, cur_is_read);
            end
            if (reset) begin
                exp_rdata = '0;
                exp_err   = 0;
            end else if (err_next) begin
                exp_err = 1;
            end
            err_next = 0;
        end
    end

    // Called at posedge+2 of the cycle in which the request is to be accepted.
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [255:0] wline, input logic [255:0] mline,
                          input int stall, input bit deassert,
                          output int lat, output logic [31:0] addr_seen);
        cur_is_read  = rd;
        cur_addr     = addr;
        cur_line     = mline;
        cur_wline    = wline;
        mem_line     = mline;
        stall_n      = stall;
        beats_done   = 0;
        outstanding  = 1;
        line_read    = rd;
        line_write   = wr;
        line_address = addr;
        line_wdata   = wline;
        if (rd && wr) err_next = 1;
        lat = -1;
        addr_seen = '0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #2;
            if (n == 0) chk("busy_at_accept", busy, 0);
            if (n == 1) begin
                chk("busy_in_burst", busy, 1);
                addr_seen  = burst_address;
                line_wdata = ~wline;
            end
            if (line_resp) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) chk("resp_timeout", line_resp, 1);
        chk("latency", lat, 4 * (stall + 1) + (FAST ? 0 : 1));
        chk("beat_count", beats_done, 4);
        @(posedge clk);
        #2;
        if (deassert) begin
            line_read  = 0;
            line_write = 0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] aseen;
        logic [255:0] l3, l4, l5, l6;
        reset = 1; line_read = 0; line_write = 0; line_address = '0; line_wdata = '0;
        repeat (3) @(posedge clk);
        #2;
        reset = 0;
        exp_rdata = '0;
        exp_err = 0;
        mon_en = 1;
        @(negedge clk);
        #2;
        chk("rst_line_rdata", line_rdata, 0);
        chk("rst_line_resp", line_resp, 0);
        chk("rst_burst_address", burst_address, 0);
        chk("rst_burst_read", burst_read, 0);
        chk("rst_burst_write", burst_write, 0);
        chk("rst_burst_wdata", burst_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #2;

        // Zero-wait read with unaligned address.
        do_txn(1, 0, 32'h0000_1234, '0, L1, 0, 1, lat, aseen);
        chk("t1_latency_literal", lat, FAST ? 4 : 5);
        chk("t1_burst_address_literal", aseen, 32'h0000_1220);
        chk("t1_rdata_literal", line_rdata, L1);

        // Write with two stall cycles per beat; line_rdata must keep the earlier read.
        do_txn(0, 1, 32'h8000_0040, W2, 256'h5A5A, 2, 1, lat, aseen);
        chk("t2_latency_literal", lat, FAST ? 12 : 13);
        chk("t2_burst_address_literal", aseen, 32'h8000_0040);
        chk("t6_rdata_kept_after_write", line_rdata, L1);

        // Read after write replaces line_rdata.
        l3 = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
        do_txn(1, 0, 32'h00AB_CDFF, '0, l3, 1, 1, lat, aseen);
        chk("t6_rdata_new_read", line_rdata, l3);

        // Back-to-back: request held past line_resp starts a second burst at the same address.
        l4 = {64'hA4, 64'hA3, 64'hA2, 64'hA1};
        l5 = {64'hB4, 64'hB3, 64'hB2, 64'hB1};
        do_txn(1, 0, 32'h0000_4000, '0, l4, 0, 0, lat, aseen);
        do_txn(1, 0, 32'h0000_4000, '0, l5, 0, 1, lat, aseen);
        chk("t5_second_burst_address", aseen, 32'h0000_4000);
        chk("t5_rdata_second", line_rdata, l5);

        // Reset after beat 2 of a read.
        cur_is_read = 1; cur_addr = 32'h0000_2000; cur_line = l3; mem_line = l3; stall_n = 0;
        beats_done = 0; outstanding = 1;
        line_read = 1; line_address = 32'h0000_2000;
        repeat (4) begin @(posedge clk); #2; end
        chk("t3_beats_before_reset", beats_done, 3);
        reset = 1; line_read = 0; outstanding = 0;
        @(posedge clk);
        #2;
        reset = 0;
        @(negedge clk);
        #2;
        chk("t3_burst_read_after_reset", burst_read, 0);
        chk("t3_busy_after_reset", busy, 0);
        chk("t3_no_line_resp", line_resp, 0);
        chk("t3_rdata_cleared", line_rdata, 0);
        @(posedge clk);
        #2;
        do_txn(1, 0, 32'h0000_2000, '0, l4, 0, 1, lat, aseen);
        chk("t3_read_after_reset", line_rdata, l4);

        // Simultaneous read and write: served as read, sticky err.
        l6 = {64'hC4, 64'hC3, 64'hC2, 64'hC1};
        do_txn(1, 1, 32'h0000_0100, W2, l6, 0, 1, lat, aseen);
        chk("t4_err_set", err, 1);
        chk("t4_served_as_read", line_rdata, l6);
        do_txn(0, 1, 32'h0000_0200, W2, '0, 0, 1, lat, aseen);
        chk("t4_err_sticky", err, 1);

        // Reset clears err; burst_resp while idle sets it again.
        reset = 1;
        @(posedge clk);
        #2;
        reset = 0;
        @(negedge clk);
        #2;
        chk("t7_err_cleared", err, 0);
        @(posedge clk);
        #2;
        force_resp = 1;
        err_next = 1;
        @(posedge clk);
        #2;
        force_resp = 0;
        @(negedge clk);
        #2;
        chk("t7_err_idle_resp", err, 1);
        chk("t7_still_idle", busy, 0);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
